vga_sync_gen: RTL

//  Produces the raster timing that pong_graph consumes: pix_x/pix_y, video_on, hsync/vsync, pixel tick, frame tick.

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/pix_tick_div.sv | 34 +++
 rtl/vga_sync_gen.sv | 88 ++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA raster timing constants (640x480@60 defaults) used by the sync
// generator and the pixel generators.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;

    localparam int unsigned HD = 640;
    localparam int unsigned HF = 16;
    localparam int unsigned HB = 48;
    localparam int unsigned HR = 96;
    localparam int unsigned VD = 480;
    localparam int unsigned VF = 10;
    localparam int unsigned VB = 33;
    localparam int unsigned VR = 2;

    localparam int unsigned H_END = HD + HF + HB + HR - 1;
    localparam int unsigned V_END = VD + VF + VB + VR - 1;

    // True when v lies in [lo, lo+len-1].
    function automatic logic in_span(logic [COORD_W-1:0] v, int unsigned lo, int unsigned len);
        return (v >= COORD_W'(lo)) && (v <= COORD_W'(lo + len - 1));
    endfunction

endpackage

// File: rtl/pix_tick_div.sv
// Divides clk down to a registered one-clk pixel strobe every DIV cycles.
module pix_tick_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             p_tick_q, p_tick_d;
    logic             at_last;

    always_comb begin
        at_last   = (div_cnt_q == CNT_W'(DIV - 1));
        div_cnt_d = at_last ? '0 : div_cnt_q + CNT_W'(1);
        p_tick_d  = at_last;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
            p_tick_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            p_tick_q  <= p_tick_d;
        end
    end

    assign p_tick = p_tick_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel/line counters, skew-free syncs, video_on and a
// one-clk frame_tick coincident with the first clk of pixel (0,0).
module vga_sync_gen #(
    parameter int unsigned HD       = vga_timing_pkg::HD,
    parameter int unsigned HF       = vga_timing_pkg::HF,
    parameter int unsigned HB       = vga_timing_pkg::HB,
    parameter int unsigned HR       = vga_timing_pkg::HR,
    parameter int unsigned VD       = vga_timing_pkg::VD,
    parameter int unsigned VF       = vga_timing_pkg::VF,
    parameter int unsigned VB       = vga_timing_pkg::VB,
    parameter int unsigned VR       = vga_timing_pkg::VR,
    parameter int unsigned DIV      = 4,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic                                clk,
    input  logic                                reset,
    output logic                                p_tick,
    output logic [vga_timing_pkg::COORD_W-1:0]  pix_x,
    output logic [vga_timing_pkg::COORD_W-1:0]  pix_y,
    output logic                                video_on,
    output logic                                hsync,
    output logic                                vsync,
    output logic                                frame_tick
);

    import vga_timing_pkg::*;

    localparam int unsigned H_MAX = HD + HF + HB + HR - 1;
    localparam int unsigned V_MAX = VD + VF + VB + VR - 1;

    logic [COORD_W-1:0] pix_x_q, pix_x_d;
    logic [COORD_W-1:0] pix_y_q, pix_y_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               frame_tick_q, frame_tick_d;
    logic               x_wrap, y_wrap;

    pix_tick_div #(.DIV(DIV)) u_pix_tick_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    // Out-of-range counts are treated as the last value so they wrap to 0.
    always_comb begin
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        frame_tick_d = 1'b0;
        x_wrap       = (pix_x_q >= COORD_W'(H_MAX));
        y_wrap       = (pix_y_q >= COORD_W'(V_MAX));
        if (p_tick) begin
            if (x_wrap) begin
                pix_x_d      = '0;
                pix_y_d      = y_wrap ? '0 : pix_y_q + COORD_W'(1);
                frame_tick_d = y_wrap;
            end else begin
                pix_x_d = pix_x_q + COORD_W'(1);
            end
        end
        // Syncs follow the next counter values so they move with pix_x/pix_y.
        hsync_d = in_span(pix_x_d, HD + HF, HR) ? SYNC_POL : ~SYNC_POL;
        vsync_d = in_span(pix_y_d, VD + VF, VR) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            hsync_q      <= ~SYNC_POL;
            vsync_q      <= ~SYNC_POL;
            frame_tick_q <= 1'b0;
        end else begin
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_tick = frame_tick_q;
    assign video_on   = (pix_x_q < COORD_W'(HD)) && (pix_y_q < COORD_W'(VD));

endmodule
